mem_tg_csr_responder: RTL
=========================

Name: mem_tg_csr_responder

Overview:
Avalon-MM CSR responder for the memory traffic generator (TG) register window at MEM_TG_CFG_OFFSET. Host CSR writes program TG configuration; the block launches and clears the TG core and reports status and counters. It sits between the AFU CSR decoder and the TG core, and is the slave end of the TG address map that host tests drive.

Parameters:
TG_VERSION_VAL, 169, value returned at TG_VERSION (0x000)
ADDR_W, 12, byte address width (10-bit word index + 2-bit byte offset)
DATA_W, 32, CSR data width (fixed 32)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
avs_address  in  12  byte address; bits [1:0] ignored
avs_write  in  1  write strobe
avs_read  in  1  read strobe
avs_writedata  in  32  write data
avs_byteenable  in  4  per-byte write enable
avs_waitrequest  out  1  stall
avs_readdata  out  32  read data
avs_readdatavalid  out  1  read data strobe
avs_response  out  2  00=OKAY, 10=SLVERR
tg_start  out  1  one-cycle launch pulse to core
tg_clear  out  1  one-cycle clear pulse to core
tg_loop_count, tg_write_count, tg_read_count, tg_burst_length  out  32 each  configuration
tg_addr_mode_wr, tg_addr_mode_rd  out  2 each  address mode
tg_seq_start_addr_wr, tg_seq_start_addr_rd  out  64 each  start addresses
tg_data_seed  out  32  data generator seed
tg_done  in  1  core completion pulse
tg_pass  in  1  core pass flag, sampled on tg_done
tg_fail_evt  in  1  per-beat mismatch pulse
tg_fail_addr  in  64  address of the mismatching beat
tg_rd_evt  in  1  per-beat read-return pulse

Behaviour:
- Reset: all config registers take TG defaults: loop/write/read/burst = 1; addr modes = 2; start addresses = 0; seed = 0x5A5A5A5A. Counters, flags and state are cleared. avs_readdatavalid=0, avs_response=0, tg_start=0, tg_clear=0. avs_waitrequest=1 while rst and for one cycle after rst deasserts, 0 otherwise.
- Reads: fixed 1-cycle latency. avs_readdatavalid pulses the cycle after avs_read is accepted; no back-pressure.
- Writes: take effect on the cycle after acceptance and honour avs_byteenable per byte. A read and write in the same cycle are both serviced; the read returns the pre-write value.
- State machine, IDLE/RUN/DONE:
  - START write (0x004, any data) in IDLE or DONE: tg_start pulses, pass/fail/complete flags and all counters are zeroed, next state RUN.
  - START write in RUN is ignored.
  - tg_done in RUN: capture tg_pass into PASS (0x088) and !tg_pass into FAIL (0x08C), set TEST_COMPLETE (0x0A8) bit0, next state DONE.
  - CLEAR write (0x020) in any state: tg_clear pulses, counters and flags are zeroed, next state IDLE.
  - CLEAR in the same cycle as tg_done: CLEAR wins.
- Config writes (0x008–0x01C, 0x040, 0x044, 0x048, 0x074, 0x078, 0x080, 0x400) in RUN are dropped, with response OKAY.
- Counters, active only in RUN:
  - FAIL_COUNT (0x090/0x094) and TOTAL_READ_COUNT (0x0A0/0x0A4) are 64-bit and saturate at all-ones.
  - FIRST_FAIL_ADDR (0x098/0x09C) latches tg_fail_addr on the first tg_fail_evt after start; later events do not overwrite it.
- 64-bit coherence: reading an _L register snapshots its _H half into a shadow register. The following _H read returns the shadow. An _H read with no preceding _L read returns the live value.
- Unmapped addresses: reads return 0, writes are dropped.

Optional Feature:
MEM_TG_CSR_ERR_RESP_EN
- Defined: any access to an unmapped address returns avs_response=2'b10 (SLVERR) with the readdatavalid pulse for reads; for writes, a one-cycle SLVERR indication on avs_response.
  - Config writes dropped in RUN also return SLVERR.
  - ERROR_REPORT (0x0EC) bit0 is set sticky on any SLVERR and cleared by CLEAR.
- Undefined: avs_response is tied to 0 and 0x0EC reads as 0.

Test Plan:
- Reset, then read 0x000, 0x008, 0x048, 0x400 -> 169, 1, 2, 0x5A5A5A5A, each with readdatavalid exactly 1 cycle after the read.
- Write 0x008 = 0x0000_0010, then write 0x004 -> tg_start pulses 1 cycle and tg_loop_count=16. Then write 0x008 = 5 while in RUN -> readback still 16.
- In RUN, drive 3 tg_fail_evt with addresses 0x100, 0x200, 0x300, then tg_done with tg_pass=0 -> FAIL_COUNT_L=3, FIRST_FAIL_ADDR_L=0x100, FAIL=1, PASS=0, TEST_COMPLETE=1.
- Preload TOTAL_READ_COUNT to 0xFFFFFFFF via 2^32−1 tg_rd_evt (forced), read _L, add one more tg_rd_evt, then read _H -> _L=0xFFFFFFFF and _H=0 (shadow value); a fresh _H read returns 1.
- Assert CLEAR and tg_done in the same cycle -> tg_clear pulses, state IDLE, TEST_COMPLETE=0.
- With MEM_TG_CSR_ERR_RESP_EN defined, read 0x3FC -> readdata=0, response=2'b10, and 0x0EC bit0=1; without the macro -> response=0.

Source files
------------

// File: rtl/mem_tg_csr_responder_if.sv
// mem_tg_csr_responder_if
// Avalon-MM CSR bus between the AFU CSR decoder (master) and the memory
// traffic generator CSR responder (slave).
//   avs_address        byte address, bits [1:0] ignored by the slave
//   avs_write/avs_read write and read strobes
//   avs_writedata      write data
//   avs_byteenable     per-byte write enable
//   avs_waitrequest    slave stall
//   avs_readdata       read data, valid with avs_readdatavalid
//   avs_readdatavalid  one-cycle read data strobe
//   avs_response       2'b00 OKAY, 2'b10 SLVERR
interface mem_tg_csr_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avs_address;
    logic                avs_write;
    logic                avs_read;
    logic [DATA_W-1:0]   avs_writedata;
    logic [DATA_W/8-1:0] avs_byteenable;
    logic                avs_waitrequest;
    logic [DATA_W-1:0]   avs_readdata;
    logic                avs_readdatavalid;
    logic [1:0]          avs_response;

    modport master (
        output avs_address, avs_write, avs_read, avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response
    );

    modport slave (
        input  avs_address, avs_write, avs_read, avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response
    );
endinterface

// File: rtl/mem_tg_csr_responder.sv
// mem_tg_csr_responder
// Avalon-MM CSR responder for the memory traffic generator register window.
// Host writes program the TG configuration, START/CLEAR launch and reset the
// core, and status/counters are read back with 64-bit coherent snapshots.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   avs                 Avalon-MM slave (mem_tg_csr_responder_if.slave)
//   tg_start, tg_clear  one-cycle pulses to the TG core
//   tg_* config         loop/write/read/burst counts, address modes,
//                       sequential start addresses, data seed
//   tg_done, tg_pass    completion pulse and pass flag from the core
//   tg_fail_evt/addr    per-beat mismatch pulse and its address
//   tg_rd_evt           per-beat read-return pulse
//
// Optional build macro: MEM_TG_CSR_ERR_RESP_EN
//   defined   -> SLVERR on unmapped accesses and on config writes dropped in
//                RUN; sticky ERROR_REPORT bit0 at 0x0EC, cleared by CLEAR.
//   undefined -> avs_response tied to OKAY, 0x0EC reads 0.
//
// Register map (byte addresses):
//   0x000 VERSION (RO)          0x004 START (WO)        0x020 CLEAR (WO)
//   0x008 LOOP_COUNT            0x00C WRITE_COUNT       0x010 READ_COUNT
//   0x014 BURST_LENGTH          0x018/0x01C SEQ_START_ADDR_WR L/H
//   0x040/0x044 SEQ_START_ADDR_RD L/H                   0x048 ADDR_MODE_WR
//   0x074 ADDR_MODE_RD          0x078 WRITE_REPEAT      0x080 READ_REPEAT
//   0x400 DATA_SEED             0x088 PASS              0x08C FAIL
//   0x090/0x094 FAIL_COUNT L/H  0x098/0x09C FIRST_FAIL_ADDR L/H
//   0x0A0/0x0A4 TOTAL_READ_COUNT L/H                    0x0A8 TEST_COMPLETE
//   0x0EC ERROR_REPORT
module mem_tg_csr_responder #(
    parameter logic [31:0] TG_VERSION_VAL = 32'd169,
    parameter int          ADDR_W         = 12,
    parameter int          DATA_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_tg_csr_responder_if.slave avs,
    output logic                 tg_start,
    output logic                 tg_clear,
    output logic [31:0]          tg_loop_count,
    output logic [31:0]          tg_write_count,
    output logic [31:0]          tg_read_count,
    output logic [31:0]          tg_burst_length,
    output logic [1:0]           tg_addr_mode_wr,
    output logic [1:0]           tg_addr_mode_rd,
    output logic [63:0]          tg_seq_start_addr_wr,
    output logic [63:0]          tg_seq_start_addr_rd,
    output logic [31:0]          tg_data_seed,
    input  logic                 tg_done,
    input  logic                 tg_pass,
    input  logic                 tg_fail_evt,
    input  logic [63:0]          tg_fail_addr,
    input  logic                 tg_rd_evt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] ADR_VERSION   = 12'h000;
    localparam logic [ADDR_W-1:0] ADR_START     = 12'h004;
    localparam logic [ADDR_W-1:0] ADR_LOOP      = 12'h008;
    localparam logic [ADDR_W-1:0] ADR_WCOUNT    = 12'h00C;
    localparam logic [ADDR_W-1:0] ADR_RCOUNT    = 12'h010;
    localparam logic [ADDR_W-1:0] ADR_BURST     = 12'h014;
    localparam logic [ADDR_W-1:0] ADR_SA_WR_L   = 12'h018;
    localparam logic [ADDR_W-1:0] ADR_SA_WR_H   = 12'h01C;
    localparam logic [ADDR_W-1:0] ADR_CLEAR     = 12'h020;
    localparam logic [ADDR_W-1:0] ADR_SA_RD_L   = 12'h040;
    localparam logic [ADDR_W-1:0] ADR_SA_RD_H   = 12'h044;
    localparam logic [ADDR_W-1:0] ADR_MODE_WR   = 12'h048;
    localparam logic [ADDR_W-1:0] ADR_MODE_RD   = 12'h074;
    localparam logic [ADDR_W-1:0] ADR_WREPEAT   = 12'h078;
    localparam logic [ADDR_W-1:0] ADR_RREPEAT   = 12'h080;
    localparam logic [ADDR_W-1:0] ADR_PASS      = 12'h088;
    localparam logic [ADDR_W-1:0] ADR_FAIL      = 12'h08C;
    localparam logic [ADDR_W-1:0] ADR_FC_L      = 12'h090;
    localparam logic [ADDR_W-1:0] ADR_FC_H      = 12'h094;
    localparam logic [ADDR_W-1:0] ADR_FA_L      = 12'h098;
    localparam logic [ADDR_W-1:0] ADR_FA_H      = 12'h09C;
    localparam logic [ADDR_W-1:0] ADR_RC_L      = 12'h0A0;
    localparam logic [ADDR_W-1:0] ADR_RC_H      = 12'h0A4;
    localparam logic [ADDR_W-1:0] ADR_COMPLETE  = 12'h0A8;
    localparam logic [ADDR_W-1:0] ADR_ERR_REP   = 12'h0EC;
    localparam logic [ADDR_W-1:0] ADR_SEED      = 12'h400;

    // Merge write data into a register honouring the per-byte enables.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_v[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

    logic [1:0]          state_r;
    logic                wait_r;
    logic                wait_hold_r;
    logic                rvalid_r;
    logic [DATA_W-1:0]   rdata_r;
    logic [31:0]         wrepeat_r;
    logic [31:0]         rrepeat_r;
    logic                pass_r;
    logic                fail_r;
    logic                complete_r;
    logic [63:0]         fail_cnt_r;
    logic [63:0]         total_rd_cnt_r;
    logic [63:0]         first_addr_r;
    logic                first_seen_r;
    logic [31:0]         sh_fc_r;
    logic [31:0]         sh_fa_r;
    logic [31:0]         sh_rc_r;
    logic                sh_fc_vld_r;
    logic                sh_fa_vld_r;
    logic                sh_rc_vld_r;

    logic [ADDR_W-1:0]   addr_s;
    logic [31:0]         wdata_s;
    logic [3:0]          be_s;
    logic                rd_acc_s;
    logic                wr_acc_s;
    logic                start_s;
    logic                clear_s;
    logic                cfg_wr_en_s;
    logic                is_cfg_s;
    logic                mapped_s;
    logic                err_rep_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                unused_addr_s;

    assign addr_s        = {avs.avs_address[ADDR_W-1:2], 2'b00};
    assign unused_addr_s = ^avs.avs_address[1:0];
    assign wdata_s       = avs.avs_writedata;
    assign be_s          = avs.avs_byteenable;
    assign rd_acc_s      = avs.avs_read  & ~wait_r;
    assign wr_acc_s      = avs.avs_write & ~wait_r;
    // START is only honoured outside RUN; CLEAR is honoured everywhere.
    assign start_s       = wr_acc_s & (addr_s == ADR_START) & (state_r != ST_RUN);
    assign clear_s       = wr_acc_s & (addr_s == ADR_CLEAR);
    // Config is frozen while the core is running.
    assign cfg_wr_en_s   = wr_acc_s & is_cfg_s & (state_r != ST_RUN);

    assign avs.avs_waitrequest   = wait_r;
    assign avs.avs_readdatavalid = rvalid_r;
    assign avs.avs_readdata      = rdata_r;

    // Address decode: read mux, mapped flag and config-register flag.
    // _H halves return the shadow when a preceding _L read armed it.
    always_comb begin
        rd_data_s = 32'd0;
        mapped_s  = 1'b1;
        is_cfg_s  = 1'b0;
        case (addr_s)
            ADR_VERSION:  rd_data_s = TG_VERSION_VAL;
            ADR_START:    rd_data_s = 32'd0;
            ADR_CLEAR:    rd_data_s = 32'd0;
            ADR_LOOP:     begin rd_data_s = tg_loop_count;               is_cfg_s = 1'b1; end
            ADR_WCOUNT:   begin rd_data_s = tg_write_count;              is_cfg_s = 1'b1; end
            ADR_RCOUNT:   begin rd_data_s = tg_read_count;               is_cfg_s = 1'b1; end
            ADR_BURST:    begin rd_data_s = tg_burst_length;             is_cfg_s = 1'b1; end
            ADR_SA_WR_L:  begin rd_data_s = tg_seq_start_addr_wr[31:0];  is_cfg_s = 1'b1; end
            ADR_SA_WR_H:  begin rd_data_s = tg_seq_start_addr_wr[63:32]; is_cfg_s = 1'b1; end
            ADR_SA_RD_L:  begin rd_data_s = tg_seq_start_addr_rd[31:0];  is_cfg_s = 1'b1; end
            ADR_SA_RD_H:  begin rd_data_s = tg_seq_start_addr_rd[63:32]; is_cfg_s = 1'b1; end
            ADR_MODE_WR:  begin rd_data_s = {30'd0, tg_addr_mode_wr};    is_cfg_s = 1'b1; end
            ADR_MODE_RD:  begin rd_data_s = {30'd0, tg_addr_mode_rd};    is_cfg_s = 1'b1; end
            ADR_WREPEAT:  begin rd_data_s = wrepeat_r;                   is_cfg_s = 1'b1; end
            ADR_RREPEAT:  begin rd_data_s = rrepeat_r;                   is_cfg_s = 1'b1; end
            ADR_SEED:     begin rd_data_s = tg_data_seed;                is_cfg_s = 1'b1; end
            ADR_PASS:     rd_data_s = {31'd0, pass_r};
            ADR_FAIL:     rd_data_s = {31'd0, fail_r};
            ADR_FC_L:     rd_data_s = fail_cnt_r[31:0];
            ADR_FC_H:     rd_data_s = sh_fc_vld_r ? sh_fc_r : fail_cnt_r[63:32];
            ADR_FA_L:     rd_data_s = first_addr_r[31:0];
            ADR_FA_H:     rd_data_s = sh_fa_vld_r ? sh_fa_r : first_addr_r[63:32];
            ADR_RC_L:     rd_data_s = total_rd_cnt_r[31:0];
            ADR_RC_H:     rd_data_s = sh_rc_vld_r ? sh_rc_r : total_rd_cnt_r[63:32];
            ADR_COMPLETE: rd_data_s = {31'd0, complete_r};
            ADR_ERR_REP:  rd_data_s = {31'd0, err_rep_s};
            default:      begin rd_data_s = 32'd0; mapped_s = 1'b0; end
        endcase
    end

    // Waitrequest: held through reset and one cycle beyond it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_hold_r <= 1'b1;
            wait_r      <= 1'b1;
        end else begin
            wait_hold_r <= 1'b0;
            wait_r      <= wait_hold_r;
        end
    end

    // Configuration registers with TG defaults and byte-enabled writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tg_loop_count        <= 32'd1;
            tg_write_count       <= 32'd1;
            tg_read_count        <= 32'd1;
            tg_burst_length      <= 32'd1;
            tg_addr_mode_wr      <= 2'd2;
            tg_addr_mode_rd      <= 2'd2;
            tg_seq_start_addr_wr <= 64'd0;
            tg_seq_start_addr_rd <= 64'd0;
            tg_data_seed         <= 32'h5A5A_5A5A;
            wrepeat_r            <= 32'd1;
            rrepeat_r            <= 32'd1;
        end else if (cfg_wr_en_s) begin
            case (addr_s)
                ADR_LOOP:    tg_loop_count   <= be_merge(tg_loop_count,   wdata_s, be_s);
                ADR_WCOUNT:  tg_write_count  <= be_merge(tg_write_count,  wdata_s, be_s);
                ADR_RCOUNT:  tg_read_count   <= be_merge(tg_read_count,   wdata_s, be_s);
                ADR_BURST:   tg_burst_length <= be_merge(tg_burst_length, wdata_s, be_s);
                ADR_SA_WR_L: tg_seq_start_addr_wr[31:0]  <= be_merge(tg_seq_start_addr_wr[31:0],  wdata_s, be_s);
                ADR_SA_WR_H: tg_seq_start_addr_wr[63:32] <= be_merge(tg_seq_start_addr_wr[63:32], wdata_s, be_s);
                ADR_SA_RD_L: tg_seq_start_addr_rd[31:0]  <= be_merge(tg_seq_start_addr_rd[31:0],  wdata_s, be_s);
                ADR_SA_RD_H: tg_seq_start_addr_rd[63:32] <= be_merge(tg_seq_start_addr_rd[63:32], wdata_s, be_s);
                ADR_MODE_WR: if (be_s[0]) tg_addr_mode_wr <= wdata_s[1:0];
                ADR_MODE_RD: if (be_s[0]) tg_addr_mode_rd <= wdata_s[1:0];
                ADR_WREPEAT: wrepeat_r    <= be_merge(wrepeat_r,    wdata_s, be_s);
                ADR_RREPEAT: rrepeat_r    <= be_merge(rrepeat_r,    wdata_s, be_s);
                ADR_SEED:    tg_data_seed <= be_merge(tg_data_seed, wdata_s, be_s);
                default:     begin end
            endcase
        end
    end

    // Run control: IDLE/RUN/DONE, launch/clear pulses, result flags and
    // counters. CLEAR takes priority over START and over a same-cycle tg_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            tg_start       <= 1'b0;
            tg_clear       <= 1'b0;
            pass_r         <= 1'b0;
            fail_r         <= 1'b0;
            complete_r     <= 1'b0;
            fail_cnt_r     <= 64'd0;
            total_rd_cnt_r <= 64'd0;
            first_addr_r   <= 64'd0;
            first_seen_r   <= 1'b0;
        end else begin
            tg_start <= 1'b0;
            tg_clear <= 1'b0;
            if (clear_s || start_s) begin
                tg_clear       <= clear_s;
                tg_start       <= ~clear_s;
                state_r        <= clear_s ? ST_IDLE : ST_RUN;
                pass_r         <= 1'b0;
                fail_r         <= 1'b0;
                complete_r     <= 1'b0;
                fail_cnt_r     <= 64'd0;
                total_rd_cnt_r <= 64'd0;
                first_addr_r   <= 64'd0;
                first_seen_r   <= 1'b0;
            end else if (state_r == ST_RUN) begin
                if (tg_rd_evt) begin
                    total_rd_cnt_r <= sat_inc(total_rd_cnt_r);
                end
                if (tg_fail_evt) begin
                    fail_cnt_r <= sat_inc(fail_cnt_r);
                    // Only the first mismatch after START is recorded.
                    if (!first_seen_r) begin
                        first_addr_r <= tg_fail_addr;
                        first_seen_r <= 1'b1;
                    end
                end
                if (tg_done) begin
                    pass_r     <= tg_pass;
                    fail_r     <= ~tg_pass;
                    complete_r <= 1'b1;
                    state_r    <= ST_DONE;
                end
            end
        end
    end

    // Read return path: 1-cycle latency, plus _H shadow capture on _L reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r    <= 1'b0;
            rdata_r     <= 32'd0;
            sh_fc_r     <= 32'd0;
            sh_fa_r     <= 32'd0;
            sh_rc_r     <= 32'd0;
            sh_fc_vld_r <= 1'b0;
            sh_fa_vld_r <= 1'b0;
            sh_rc_vld_r <= 1'b0;
        end else begin
            rvalid_r <= rd_acc_s;
            if (rd_acc_s) begin
                rdata_r <= rd_data_s;
                case (addr_s)
                    ADR_FC_L: begin sh_fc_r <= fail_cnt_r[63:32];     sh_fc_vld_r <= 1'b1; end
                    ADR_FA_L: begin sh_fa_r <= first_addr_r[63:32];   sh_fa_vld_r <= 1'b1; end
                    ADR_RC_L: begin sh_rc_r <= total_rd_cnt_r[63:32]; sh_rc_vld_r <= 1'b1; end
                    ADR_FC_H: sh_fc_vld_r <= 1'b0;
                    ADR_FA_H: sh_fa_vld_r <= 1'b0;
                    ADR_RC_H: sh_rc_vld_r <= 1'b0;
                    default:  begin end
                endcase
            end
        end
    end

`ifdef MEM_TG_CSR_ERR_RESP_EN
    logic [1:0] resp_r;
    logic       err_rep_r;
    logic       err_s;

    assign err_s = ((rd_acc_s | wr_acc_s) & ~mapped_s)
                 | (wr_acc_s & is_cfg_s & (state_r == ST_RUN));

    // Error response: one-cycle SLVERR aligned with the read data strobe,
    // and a sticky report bit that CLEAR resets.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_r    <= 2'b00;
            err_rep_r <= 1'b0;
        end else begin
            resp_r <= err_s ? 2'b10 : 2'b00;
            if (err_s) begin
                err_rep_r <= 1'b1;
            end else if (clear_s) begin
                err_rep_r <= 1'b0;
            end
        end
    end

    assign avs.avs_response = resp_r;
    assign err_rep_s        = err_rep_r;
`else
    logic unused_map_s;

    assign unused_map_s     = mapped_s;
    assign avs.avs_response = 2'b00;
    assign err_rep_s        = 1'b0;
`endif

endmodule
